// File: rtl/spi_pkg.sv
// Shared definitions for the AES-over-SPI master: FSM encoding, phase lengths
// and the load/readback mode levels.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMsg,
        StKey,
        StGap,
        StRead,
        StFin
    } state_t;

    localparam int unsigned MSG_BITS    = 128;
    localparam int unsigned READ_CYCLES = 129;
    // Wide enough for 255 gap cycles, 256 key bits and 129 read cycles.
    localparam int unsigned CNT_W       = 9;

    localparam logic MODE_ENCR = 1'b0;
    localparam logic MODE_DECR = 1'b1;

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable down-counter that times every phase of the SPI master; tc flags zero.
module spi_bit_counter
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_master.sv
// SPI master that shifts an AES block and key out LSB first, waits, then reads
// the 128-bit result back from the slave on the shared system clock.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned Nk          = 4,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MSG_BITS-1:0] msg_in,
    input  logic [Nk*32-1:0]    key_in,
    input  logic                SOMI,
    output logic                SIMO,
    output logic                CSS,
    output logic                mode,
    output logic                busy,
    output logic                done,
    output logic [MSG_BITS-1:0] result
);

    localparam int unsigned KEY_BITS = Nk * 32;

    state_t              state;
    logic [MSG_BITS-1:0] msg_sr;
    logic [KEY_BITS-1:0] key_sr;
    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_tc;

    assign busy = (state != StIdle);

    // Each phase loads the counter with its length minus one on entry.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            StIdle: if (start) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(MSG_BITS - 1);
            end
            StMsg: if (cnt_tc) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(KEY_BITS - 1);
            end
            StKey: if (cnt_tc) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(WAIT_CYCLES - 1);
            end
            StGap: if (cnt_tc) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(READ_CYCLES - 1);
            end
            default: ;
        endcase
    end

    spi_bit_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (busy),
        .load_val (cnt_val),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            msg_sr <= '0;
            key_sr <= '0;
            SIMO   <= 1'b0;
            CSS    <= 1'b1;
            mode   <= MODE_ENCR;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                StIdle: if (start) begin
                    SIMO   <= msg_in[0];
                    msg_sr <= msg_in >> 1;
                    key_sr <= key_in;
                    CSS    <= 1'b0;
                    state  <= StMsg;
                end
                StMsg: if (cnt_tc) begin
                    SIMO   <= key_sr[0];
                    key_sr <= key_sr >> 1;
                    state  <= StKey;
                end else begin
                    SIMO   <= msg_sr[0];
                    msg_sr <= msg_sr >> 1;
                end
                StKey: if (cnt_tc) begin
                    SIMO  <= 1'b0;
                    state <= StGap;
                end else begin
                    SIMO   <= key_sr[0];
                    key_sr <= key_sr >> 1;
                end
                StGap: if (cnt_tc) begin
                    mode  <= MODE_DECR;
                    state <= StRead;
                end
                StRead: begin
                    // The slave registers SOMI, so the first read cycle carries no data.
                    if (cnt != CNT_W'(READ_CYCLES - 1)) begin
                        result <= {SOMI, result[MSG_BITS-1:1]};
                    end
                    if (cnt_tc) begin
                        mode  <= MODE_ENCR;
                        CSS   <= 1'b1;
                        done  <= 1'b1;
                        state <= StFin;
                    end
                end
                StFin: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: Nk=4 and Nk=8 instances, a registered
// slave model on SOMI and a bit-level scoreboard on SIMO.
module tb_spi_master;

    localparam int WAIT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start4, start8;
    logic [127:0] msg_in;
    logic [127:0] key4;
    logic [255:0] key8;
    logic         somi, somi_s;
    logic         simo4, css4, mode4, busy4, done4;
    logic         simo8, css8, mode8, busy8, done8;
    logic [127:0] res4, res8;

    logic         sel_m;
    logic         simo_m, css_m, mode_m, busy_m, done_m;
    logic [127:0] result_m;

    logic [127:0] resp;
    logic [127:0] last_res [2];
    logic         force_somi;
    logic [7:0]   sl_idx, sl_rd;

    int           ncmp = 0;
    int           nerr = 0;
    logic         exp_q [$];

    typedef struct {
        bit           sel;
        logic [127:0] msg;
        logic [255:0] key;
        int           exp_cycles;
        logic [127:0] exp_res;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    spi_master #(.Nk(4), .WAIT_CYCLES(WAIT)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .msg_in(msg_in), .key_in(key4),
        .SOMI(somi), .SIMO(simo4), .CSS(css4), .mode(mode4), .busy(busy4),
        .done(done4), .result(res4)
    );

    spi_master #(.Nk(8), .WAIT_CYCLES(WAIT)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .msg_in(msg_in), .key_in(key8),
        .SOMI(somi), .SIMO(simo8), .CSS(css8), .mode(mode8), .busy(busy8),
        .done(done8), .result(res8)
    );

    assign simo_m   = sel_m ? simo8 : simo4;
    assign css_m    = sel_m ? css8  : css4;
    assign mode_m   = sel_m ? mode8 : mode4;
    assign busy_m   = sel_m ? busy8 : busy4;
    assign done_m   = sel_m ? done8 : done4;
    assign result_m = sel_m ? res8  : res4;

    // Slave model: registers resp LSB first while selected in readback mode.
    always @(posedge clk) begin
        if (css_m) begin
            sl_idx <= 8'd0;
            sl_rd  <= 8'd0;
        end else if (mode_m) begin
            if (sl_idx < 8'd128) somi_s <= resp[sl_idx[6:0]];
            sl_idx <= sl_idx + 8'd1;
            sl_rd  <= sl_rd + 8'd1;
        end
    end

    assign somi = force_somi ? (mode_m && !css_m && sl_rd == 8'd0) : somi_s;

    function automatic logic [127:0] slave_fn(input logic [127:0] m, input logic [255:0] k);
        return m ^ k[127:0] ^ k[255:128] ^ 128'hc3a5_0f96_1e2d_7b48_5a5a_f00f_8421_dead;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind: 0 normal, 1 extra starts, 2 reset in READ, 3 msg_in change, 4 forced SOMI
    task automatic run_txn(input vec_t v, input int kind);
        int           k_bits;
        int           busy_cnt, ser_cnt, rd_cnt, done_cnt, done_at;
        logic         b;
        logic [127:0] exp_res;
        k_bits   = v.sel ? 256 : 128;
        busy_cnt = 0;
        ser_cnt  = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        done_at  = -1;
        exp_res  = (kind == 4) ? '0 : v.exp_res;

        resp       = v.exp_res;
        force_somi = (kind == 4);
        sel_m      = v.sel;
        msg_in     = v.msg;
        key4       = v.key[127:0];
        key8       = v.key;
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(v.msg[i]);
        for (int i = 0; i < k_bits; i++) exp_q.push_back(v.key[i]);
        for (int i = 0; i < WAIT; i++) exp_q.push_back(1'b0);

        if (v.sel) start8 = 1'b1;
        else start4 = 1'b1;
        @(negedge clk);
        chk("result_hold", result_m, last_res[v.sel]);

        for (int c = 0; c < v.exp_cycles + 6; c++) begin
            if (c > 0) @(negedge clk);
            start4 = 1'b0;
            start8 = 1'b0;
            if (!rst_n) rst_n = 1'b1;
            if (busy_m) busy_cnt++;
            if (busy_m && !css_m && !mode_m) begin
                ser_cnt++;
                b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                chk("simo", {127'd0, simo_m}, {127'd0, b});
            end
            if (mode_m) rd_cnt++;
            if (done_m) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (kind == 1 && (c == 50 || done_m)) begin
                if (v.sel) start8 = 1'b1;
                else start4 = 1'b1;
            end
            if (kind == 3 && c == 0) msg_in = '1;
            if (kind == 2 && mode_m && rd_cnt == 60 && rst_n) begin
                rst_n = 1'b0;
                #1;
                chk("rst_css", {127'd0, css_m}, 128'd1);
                chk("rst_result", result_m, '0);
                chk("rst_busy", {127'd0, busy_m}, '0);
                chk("rst_mode", {127'd0, mode_m}, '0);
                chk("rst_simo", {127'd0, simo_m}, '0);
            end
        end

        if (kind == 2) begin
            chk("rst_no_done", 128'(done_cnt), 128'd0);
            chk("rst_idle", {127'd0, busy_m}, '0);
            last_res[0] = '0;
            last_res[1] = '0;
        end else begin
            chk("busy_cycles", 128'(busy_cnt), 128'(v.exp_cycles));
            chk("done_count", 128'(done_cnt), 128'd1);
            chk("done_at", 128'(done_at), 128'(v.exp_cycles));
            chk("serial_cycles", 128'(ser_cnt), 128'(128 + k_bits + WAIT));
            chk("queue_left", 128'(exp_q.size()), 128'd0);
            chk("result", result_m, exp_res);
            last_res[v.sel] = exp_res;
        end
        force_somi = 1'b0;
    endtask

    initial begin
        logic [127:0] m_a;
        logic [255:0] k4_a, k8_a;
        rst_n       = 1'b0;
        start4      = 1'b0;
        start8      = 1'b0;
        msg_in      = '0;
        key4        = '0;
        key8        = '0;
        sel_m       = 1'b0;
        force_somi  = 1'b0;
        resp        = '0;
        last_res[0] = '0;
        last_res[1] = '0;

        m_a  = 128'h00112233445566778899aabbccddeeff;
        k4_a = {128'd0, 128'h000102030405060708090a0b0c0d0e0f};
        k8_a = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vecs[0] = '{1'b0, m_a, k4_a, 390, slave_fn(m_a, k4_a)};
        vecs[1] = '{1'b1, m_a, k8_a, 518, slave_fn(m_a, k8_a)};
        vecs[2] = '{1'b0, 128'hdeadbeef_01234567_89abcdef_cafef00d,
                    {128'd0, 128'h8000_0000_0000_0001_ffff_0000_1234_5678}, 390,
                    slave_fn(128'hdeadbeef_01234567_89abcdef_cafef00d,
                             {128'd0, 128'h8000_0000_0000_0001_ffff_0000_1234_5678})};
        vecs[3] = '{1'b0, 128'd0, {128'd0, {128{1'b1}}}, 390,
                    slave_fn(128'd0, {128'd0, {128{1'b1}}})};

        #12;
        chk("reset_css", {127'd0, css4}, 128'd1);
        chk("reset_simo", {127'd0, simo4}, '0);
        chk("reset_mode", {127'd0, mode4}, '0);
        chk("reset_busy", {127'd0, busy4}, '0);
        chk("reset_done", {127'd0, done4}, '0);
        chk("reset_result", res4, '0);
        chk("reset_css8", {127'd0, css8}, 128'd1);
        chk("reset_result8", res8, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_txn(vecs[i], 0);
        run_txn(vecs[0], 1);
        run_txn(vecs[2], 3);
        run_txn(vecs[0], 2);
        run_txn(vecs[3], 0);
        run_txn(vecs[0], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
